// File: rtl/apb_master_ctrl_if.sv
// Request/response port plus APB3 fabric signals of apb_master_ctrl.
// The master modport is the controller's view; slave is the fabric side.
interface apb_master_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int SLAVES = 2
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [ADDR_W-1:0]        req_addr;
  logic [DATA_W-1:0]        req_wdata;
  logic                     rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     rsp_error;
  logic                     rsp_timeout;
  logic [SLAVES-1:0]        psel;
  logic                     penable;
  logic                     pwrite;
  logic [ADDR_W-1:0]        paddr;
  logic [DATA_W-1:0]        pwdata;
  logic [SLAVES*DATA_W-1:0] prdata;
  logic [SLAVES-1:0]        pready;
  logic [SLAVES-1:0]        pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_error, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_error, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB3 master: valid/ready requests to SETUP/ACCESS transfers on one of
// SLAVES peripherals, with address decode, PSLVERR and wait-state timeout.
module apb_master_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int SLAVES  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset,
  apb_master_ctrl_if.master   bus
);
  localparam int SEL_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SLAVES-1:0]  psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_error_q, rsp_error_d;
  logic               rsp_timeout_q, rsp_timeout_d;

  logic [SEL_W-1:0]   req_idx;
  logic               dec_err;
  logic [SLAVES-1:0]  req_sel;
  logic               sel_ready;
  logic               sel_err;
  logic [DATA_W-1:0]  sel_rdata;

  assign req_idx = bus.req_addr[ADDR_W-1 -: SEL_W];
  assign dec_err = int'(req_idx) >= SLAVES;
  assign req_sel = SLAVES'(1) << req_idx;

  // The one-hot psel register doubles as the slave mux select.
  assign sel_ready = |(bus.pready & psel_q);
  assign sel_err   = |(bus.pslverr & psel_q);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < SLAVES; i++) begin
      if (psel_q[i]) begin
        sel_rdata |= bus.prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_error_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && dec_err) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
        end else if (bus.req_valid) begin
          state_d   = SETUP;
          psel_d    = req_sel;
          penable_d = 1'b0;
          pwrite_d  = bus.req_write;
          paddr_d   = bus.req_addr;
          pwdata_d  = bus.req_write ? bus.req_wdata : '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = sel_err;
          if (!pwrite_q && !sel_err) begin
            rsp_rdata_d = sel_rdata;
          end
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d       = IDLE;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_error   = rsp_error_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule
